// File: rtl/mem_arbiter.sv
// Arbitrates one single-port RAM between instruction fetch and load/store ports.
// A request is accepted in IDLE, then the address is held for MEM_LATENCY cycles (a single cycle for stores), then a one-cycle response follows.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MEM_LATENCY   = 1,
  parameter int unsigned DATA_PRIORITY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  output logic                  i_req_ready,
  output logic                  i_rsp_valid,
  output logic [DATA_WIDTH-1:0] i_rsp_data,
  input  logic                  d_req_valid,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic [DATA_WIDTH-1:0] d_req_wdata,
  input  logic                  d_req_we,
  output logic                  d_req_ready,
  output logic                  d_rsp_valid,
  output logic [DATA_WIDTH-1:0] d_rsp_data,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  busy
);

  localparam int unsigned CNT_WIDTH = 3;

  if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
    $error("mem_arbiter: MEM_LATENCY must be in 1..4");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  state_t                state_q, state_d;
  owner_t                owner_q, last_grant_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] i_rsp_data_q, d_rsp_data_q;
  logic                  we_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  grant_i, grant_d, accept, capture, tie_to_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Arbitration and sequencing; a tie goes to data unless round-robin says otherwise
  always_comb begin
    state_d  = state_q;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    capture  = 1'b0;
    tie_to_d = (DATA_PRIORITY != 0) || (last_grant_q == OWN_I);
    unique case (state_q)
      IDLE: begin
        grant_d = d_req_valid && (!i_req_valid || tie_to_d);
        grant_i = i_req_valid && !grant_d;
        if (grant_i || grant_d) state_d = ACCESS;
      end
      ACCESS: begin
        if (we_q) begin
          state_d = RESP;
        end else if (cnt_q == CNT_WIDTH'(1)) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign accept = (grant_i || grant_d) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q      <= OWN_I;
      last_grant_q <= OWN_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      i_rsp_data_q <= '0;
      d_rsp_data_q <= '0;
    end else begin
      if (accept) begin
        owner_q      <= grant_d ? OWN_D : OWN_I;
        last_grant_q <= grant_d ? OWN_D : OWN_I;
        addr_q       <= grant_d ? d_req_addr : i_req_addr;
        wdata_q      <= grant_d ? d_req_wdata : '0;
        we_q         <= grant_d && d_req_we;
        cnt_q        <= CNT_WIDTH'(MEM_LATENCY);
      end else if (state_q == ACCESS && !we_q) begin
        cnt_q <= cnt_q - CNT_WIDTH'(1);
      end
      // Stores report zero as their response data
      if (state_q == ACCESS && we_q) d_rsp_data_q <= '0;
      if (capture) begin
        if (owner_q == OWN_D) d_rsp_data_q <= mem_read_data;
        else                  i_rsp_data_q <= mem_read_data;
      end
    end
  end

  assign i_req_ready      = grant_i && !rst;
  assign d_req_ready      = grant_d && !rst;
  assign i_rsp_valid      = (state_q == RESP) && (owner_q == OWN_I);
  assign d_rsp_valid      = (state_q == RESP) && (owner_q == OWN_D);
  assign i_rsp_data       = i_rsp_data_q;
  assign d_rsp_data       = d_rsp_data_q;
  assign mem_address      = (state_q == IDLE) ? '0 : addr_q;
  assign mem_write_data   = wdata_q;
  assign mem_write_enable = (state_q == ACCESS) && we_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance A (latency 1, data priority), instance B (latency 3, round-robin).
// Directed vectors, corner sequences and randomized traffic against a transaction-timing model.
module tb_mem_arbiter;

  localparam int unsigned LAT_A = 1;
  localparam int unsigned LAT_B = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_iv, a_irdy, a_irv, a_dv, a_dwe, a_drdy, a_drv, a_mwe, a_busy;
  logic [31:0] a_ia, a_ird, a_da, a_dwd, a_drd, a_maddr, a_mwd, a_mrd;
  logic        b_iv, b_irdy, b_irv, b_dv, b_dwe, b_drdy, b_drv, b_mwe, b_busy;
  logic [31:0] b_ia, b_ird, b_da, b_dwd, b_drd, b_maddr, b_mwd, b_mrd;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT_A), .DATA_PRIORITY(1)) u_a (
    .clk(clk), .rst(rst),
    .i_req_valid(a_iv), .i_req_addr(a_ia), .i_req_ready(a_irdy),
    .i_rsp_valid(a_irv), .i_rsp_data(a_ird),
    .d_req_valid(a_dv), .d_req_addr(a_da), .d_req_wdata(a_dwd), .d_req_we(a_dwe),
    .d_req_ready(a_drdy), .d_rsp_valid(a_drv), .d_rsp_data(a_drd),
    .mem_address(a_maddr), .mem_write_data(a_mwd), .mem_write_enable(a_mwe),
    .mem_read_data(a_mrd), .busy(a_busy));

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT_B), .DATA_PRIORITY(0)) u_b (
    .clk(clk), .rst(rst),
    .i_req_valid(b_iv), .i_req_addr(b_ia), .i_req_ready(b_irdy),
    .i_rsp_valid(b_irv), .i_rsp_data(b_ird),
    .d_req_valid(b_dv), .d_req_addr(b_da), .d_req_wdata(b_dwd), .d_req_we(b_dwe),
    .d_req_ready(b_drdy), .d_rsp_valid(b_drv), .d_rsp_data(b_drd),
    .mem_address(b_maddr), .mem_write_data(b_mwd), .mem_write_enable(b_mwe),
    .mem_read_data(b_mrd), .busy(b_busy));

  // Memory fixtures; B's read data is scrambled with the cycle count so it changes every cycle
  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];
  logic [31:0] cyc;
  logic        mem_init;

  always @(posedge clk) begin
    if (mem_init) begin
      cyc <= 32'd0;
      for (int i = 0; i < 64; i++) begin
        mem_a[i] <= (i == 16) ? 32'h00A0_0093 : 32'h1000_0000 + 32'(i);
        mem_b[i] <= 32'h2000_0000 + 32'(i) * 32'd3;
      end
    end else begin
      cyc <= cyc + 32'd1;
      if (a_mwe) mem_a[a_maddr[5:0]] <= a_mwd;
      if (b_mwe) mem_b[b_maddr[5:0]] <= b_mwd;
    end
  end

  assign a_mrd = mem_a[a_maddr[5:0]];
  assign b_mrd = mem_b[b_maddr[5:0]] ^ cyc;

  typedef struct {
    logic        irdy, irv, drdy, drv, mwe, busy;
    logic [31:0] ird, drd, maddr, mwd;
  } obs_t;

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          we;
    logic [31:0] exp_data;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic obs_t obs(input int k);
    obs_t o;
    if (k == 0) begin
      o.irdy = a_irdy; o.irv = a_irv; o.ird = a_ird; o.drdy = a_drdy; o.drv = a_drv;
      o.drd = a_drd; o.maddr = a_maddr; o.mwd = a_mwd; o.mwe = a_mwe; o.busy = a_busy;
    end else begin
      o.irdy = b_irdy; o.irv = b_irv; o.ird = b_ird; o.drdy = b_drdy; o.drv = b_drv;
      o.drd = b_drd; o.maddr = b_maddr; o.mwd = b_mwd; o.mwe = b_mwe; o.busy = b_busy;
    end
    return o;
  endfunction

  task automatic drive(input int k, input logic iv, input logic [31:0] ia, input logic dv,
                       input logic [31:0] da, input logic [31:0] wd, input logic we);
    if (k == 0) begin
      a_iv = iv; a_ia = ia; a_dv = dv; a_da = da; a_dwd = wd; a_dwe = we;
    end else begin
      b_iv = iv; b_ia = ia; b_dv = dv; b_da = da; b_dwd = wd; b_dwe = we;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One isolated transaction on instance A, checked cycle by cycle
  task automatic run_vec(input vec_t v, input int idx);
    obs_t  o;
    string s;
    s = $sformatf("vec%0d", idx);
    drive(0, !v.is_d, v.is_d ? 32'd0 : v.addr, v.is_d, v.is_d ? v.addr : 32'd0, v.wdata, v.we);
    mid();
    o = obs(0);
    chk({s, " ready"}, v.is_d ? o.drdy : o.irdy, 1);
    chk({s, " other ready"}, v.is_d ? o.irdy : o.drdy, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    mid();
    o = obs(0);
    chk({s, " busy access"}, o.busy, 1);
    chk({s, " mem_address"}, o.maddr, v.addr);
    chk({s, " mem_we access"}, o.mwe, v.we);
    if (v.we) chk({s, " mem_write_data"}, o.mwd, v.wdata);
    tick();
    mid();
    o = obs(0);
    chk({s, " rsp_valid"}, v.is_d ? o.drv : o.irv, 1);
    chk({s, " other rsp_valid"}, v.is_d ? o.irv : o.drv, 0);
    chk({s, " rsp_data"}, v.is_d ? o.drd : o.ird, v.exp_data);
    chk({s, " busy resp"}, o.busy, 1);
    chk({s, " mem_we resp"}, o.mwe, 0);
    tick();
    mid();
    o = obs(0);
    chk({s, " busy idle"}, o.busy, 0);
    chk({s, " rsp_valid idle"}, v.is_d ? o.drv : o.irv, 0);
    chk({s, " rsp_data held"}, v.is_d ? o.drd : o.ird, v.exp_data);
    chk({s, " mem_address idle"}, o.maddr, 0);
    tick();
  endtask

  // Randomized traffic against a transaction-timing reference model
  task automatic rand_phase(input int k, input int lat, input bit dprio, input bit scr, input int ncyc);
    logic [31:0] refm [64];
    obs_t        o;
    int          free_at, rsp_at, we_at;
    bit          rsp_d, last_d, ip, dq, dwe, idle, gi, gd, we;
    logic [31:0] rsp_val, cur_addr, cur_wd, exp_id, exp_dd, ia, da, dwd, addr;
    do_reset();
    for (int i = 0; i < 64; i++) refm[i] = (k == 0) ? mem_a[i] : mem_b[i];
    free_at = 0; rsp_at = -1; we_at = -1; rsp_d = 0; last_d = 0;
    rsp_val = 0; cur_addr = 0; cur_wd = 0; exp_id = 0; exp_dd = 0;
    ip = 0; dq = 0; dwe = 0; ia = 0; da = 0; dwd = 0;
    for (int n = 0; n < ncyc; n++) begin
      if (!ip && $urandom_range(1, 0) == 1) begin
        ip = 1; ia = 32'($urandom_range(63, 0));
      end
      if (!dq && $urandom_range(1, 0) == 1) begin
        dq = 1; da = 32'($urandom_range(63, 0)); dwd = $urandom; dwe = ($urandom_range(1, 0) == 1);
      end
      drive(k, ip, ia, dq, da, dwd, dwe);
      idle = (n >= free_at);
      gd   = idle && dq && (!ip || dprio || !last_d);
      gi   = idle && ip && !gd;
      if (n == rsp_at) begin
        if (rsp_d) exp_dd = rsp_val;
        else       exp_id = rsp_val;
      end
      mid();
      o = obs(k);
      chk("rnd i_ready", o.irdy, gi);
      chk("rnd d_ready", o.drdy, gd);
      chk("rnd i_rsp_valid", o.irv, (n == rsp_at) && !rsp_d);
      chk("rnd d_rsp_valid", o.drv, (n == rsp_at) && rsp_d);
      chk("rnd i_rsp_data", o.ird, exp_id);
      chk("rnd d_rsp_data", o.drd, exp_dd);
      chk("rnd busy", o.busy, !idle);
      chk("rnd mem_we", o.mwe, n == we_at);
      chk("rnd mem_address", o.maddr, idle ? 32'd0 : cur_addr);
      if (n == we_at) chk("rnd mem_write_data", o.mwd, cur_wd);
      if (gi || gd) begin
        we       = gd && dwe;
        addr     = gd ? da : ia;
        rsp_at   = n + (we ? 2 : lat + 1);
        free_at  = n + (we ? 3 : lat + 2);
        we_at    = we ? n + 1 : -1;
        cur_addr = addr;
        cur_wd   = dwd;
        rsp_d    = gd;
        last_d   = gd;
        if (we) begin
          refm[addr[5:0]] = dwd;
          rsp_val = 32'd0;
        end else begin
          rsp_val = refm[addr[5:0]] ^ (scr ? cyc + 32'(lat) : 32'd0);
        end
        if (gd) dq = 0;
        else    ip = 0;
      end
      tick();
    end
    drive(k, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    vec_t        vecs [7];
    obs_t        o;
    int          ng;
    int          grants [4];
    logic [31:0] c_t;

    vecs[0] = '{is_d: 0, addr: 32'h10, wdata: 32'h0,         we: 0, exp_data: 32'h00A0_0093};
    vecs[1] = '{is_d: 1, addr: 32'h40, wdata: 32'hDEAD_BEEF, we: 1, exp_data: 32'h0};
    vecs[2] = '{is_d: 1, addr: 32'h40, wdata: 32'h0,         we: 0, exp_data: 32'hDEAD_BEEF};
    vecs[3] = '{is_d: 0, addr: 32'h40, wdata: 32'h0,         we: 0, exp_data: 32'hDEAD_BEEF};
    vecs[4] = '{is_d: 1, addr: 32'h11, wdata: 32'h0,         we: 0, exp_data: 32'h1000_0011};
    vecs[5] = '{is_d: 1, addr: 32'h3F, wdata: 32'h1234_5678, we: 1, exp_data: 32'h0};
    vecs[6] = '{is_d: 0, addr: 32'h3F, wdata: 32'h0,         we: 0, exp_data: 32'h1234_5678};

    // Reset state, with both requests raised to show ready is gated by reset
    rst = 1'b1;
    mem_init = 1'b1;
    drive(0, 1, 32'h4, 1, 32'h8, 32'h5, 1);
    drive(1, 1, 32'h4, 1, 32'h8, 32'h5, 0);
    tick();
    tick();
    mem_init = 1'b0;
    mid();
    for (int k = 0; k < 2; k++) begin
      o = obs(k);
      chk("reset i_ready", o.irdy, 0);
      chk("reset d_ready", o.drdy, 0);
      chk("reset i_rsp_valid", o.irv, 0);
      chk("reset d_rsp_valid", o.drv, 0);
      chk("reset i_rsp_data", o.ird, 0);
      chk("reset d_rsp_data", o.drd, 0);
      chk("reset mem_address", o.maddr, 0);
      chk("reset mem_write_data", o.mwd, 0);
      chk("reset mem_we", o.mwe, 0);
      chk("reset busy", o.busy, 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Tie on A: data first, fetch at the next IDLE
    drive(0, 1, 32'h20, 1, 32'h21, 32'h0, 0);
    mid();
    chk("tie d_ready", a_drdy, 1);
    chk("tie i_ready", a_irdy, 0);
    tick();
    drive(0, 1, 32'h20, 0, 0, 0, 0);
    mid();
    chk("tie i_ready access", a_irdy, 0);
    tick();
    mid();
    chk("tie d_rsp_valid", a_drv, 1);
    chk("tie d_rsp_data", a_drd, 32'h1000_0021);
    chk("tie i_ready resp", a_irdy, 0);
    tick();
    mid();
    chk("tie i_ready idle", a_irdy, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    mid();
    chk("tie i_rsp_valid", a_irv, 1);
    chk("tie i_rsp_data", a_ird, 32'h1000_0020);
    tick();

    // Reset during the write cycle of a store on A
    drive(0, 0, 0, 1, 32'h05, 32'hA5A5_A5A5, 1);
    mid();
    chk("rststore d_ready", a_drdy, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("rststore mem_we before", a_mwe, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rststore mem_we async", a_mwe, 0);
    chk("rststore busy async", a_busy, 0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      mid();
      chk("rststore no d_rsp", a_drv, 0);
      tick();
    end
    drive(0, 0, 0, 1, 32'h05, 32'h0, 0);
    mid();
    chk("rststore next d_ready", a_drdy, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    mid();
    chk("rststore next d_rsp_valid", a_drv, 1);
    chk("rststore mem unchanged", a_drd, 32'h1000_0005);
    tick();

    // Round-robin ties on B after reset: D, I, D, I
    for (int j = 0; j < 4; j++) grants[j] = 2;
    ng = 0;
    drive(1, 1, 32'h1, 1, 32'h2, 32'h0, 0);
    for (int c = 0; c < 40 && ng < 4; c++) begin
      mid();
      if (b_drdy || b_irdy) begin
        grants[ng] = b_drdy ? 1 : 0;
        ng++;
      end
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int j = 0; j < 4; j++) chk($sformatf("rr grant%0d is_data", j), 32'(grants[j]), (j % 2 == 0) ? 32'd1 : 32'd0);
    for (int c = 0; c < 6; c++) tick();

    // Latency-3 load on B: captured data is the memory value in cycle T+3
    drive(1, 0, 0, 1, 32'h8, 32'h0, 0);
    mid();
    chk("lat3 d_ready", b_drdy, 1);
    c_t = cyc;
    tick();
    drive(1, 1, 32'h9, 0, 0, 0, 0);
    for (int c = 1; c <= 4; c++) begin
      mid();
      chk($sformatf("lat3 i_ready T+%0d", c), b_irdy, 0);
      chk($sformatf("lat3 d_rsp_valid T+%0d", c), b_drv, c == 4);
      if (c == 4) chk("lat3 d_rsp_data", b_drd, 32'h2000_0018 ^ (c_t + 32'd3));
      tick();
    end
    mid();
    chk("lat3 i_ready after", b_irdy, 1);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 6; c++) tick();

    rand_phase(0, LAT_A, 1, 0, 400);
    rand_phase(1, LAT_B, 0, 1, 400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port memory (combinational read, synchronous write) between the instruction-fetch port and the load/store port of the core.
- Grants one requester at a time and sequences the memory access: address hold, write strobe and read-data capture.
- Returns a response pulse to the granted requester.
- Sits between the CPU datapath and a unified memory instance, and lets the core move from split instruction/data memories to a single shared RAM.

Parameters:
- ADDR_WIDTH, 32, width of all address buses
- DATA_WIDTH, 32, width of all data buses
- MEM_LATENCY, 1, cycles the address is held before read data is captured; legal 1..4, anything else is an elaboration error
- DATA_PRIORITY, 1, 1 = data port always wins a tie; 0 = round-robin on ties

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_req_valid  in  1  fetch request
- i_req_addr  in  ADDR_WIDTH  fetch address
- i_req_ready  out  1  fetch accepted this cycle when valid & ready
- i_rsp_valid  out  1  one-cycle pulse, fetch data valid
- i_rsp_data  out  DATA_WIDTH  fetched instruction
- d_req_valid  in  1  load/store request
- d_req_addr  in  ADDR_WIDTH  load/store address
- d_req_wdata  in  DATA_WIDTH  store data
- d_req_we  in  1  1 = store, 0 = load
- d_req_ready  out  1  load/store accepted this cycle
- d_rsp_valid  out  1  one-cycle pulse, load data valid or store done
- d_rsp_data  out  DATA_WIDTH  load data; 0 for stores
- mem_address  out  ADDR_WIDTH  to memory address
- mem_write_data  out  DATA_WIDTH  to memory write_data
- mem_write_enable  out  1  to memory write_enable
- mem_read_data  in  DATA_WIDTH  from memory read_data
- busy  out  1  high whenever state != IDLE

Behaviour:

Reset:
- rst high: state IDLE, counter 0, last_grant = INSTR.
- All outputs 0, including both ready signals, which are gated with ~rst.
- rst asserted mid-transaction drops the transaction; no response is ever emitted for it, and mem_write_enable falls immediately.

States: IDLE, ACCESS, RESP.

IDLE:
- Ready is asserted only to the winner; the loser sees ready = 0.
- Only one requester valid: it wins.
- Both valid: data wins if DATA_PRIORITY = 1; otherwise the port not equal to last_grant wins.
- On handshake: latch addr, wdata, we and owner; update last_grant; counter <= MEM_LATENCY; go to ACCESS.
- Requests are never accepted outside IDLE; requesters hold valid and their fields stable until ready.

ACCESS:
- mem_address = latched address. It is 0 in IDLE and holds the latched value in RESP.
- Store: mem_write_enable = 1 for exactly the first ACCESS cycle, then go to RESP.
- Load or fetch: counter decrements each cycle. In the cycle counter == 1, capture mem_read_data into the response register and go to RESP.

RESP:
- Exactly one cycle.
- Owner's rsp_valid = 1 with the registered data (0 for stores); the other rsp_valid stays 0.
- Next state is IDLE. No response backpressure; requesters must sample the pulse.

Timing (accept at cycle T):
- Read: response at T+MEM_LATENCY+1; next accept at T+MEM_LATENCY+2.
- Store: write at T+1, response at T+2, next accept at T+3.

Other rules:
- rsp_data holds its last value between pulses.
- Addresses and data pass through unmodified; no alignment checks and no byte enables.
- Counter is 3 bits.

Test Plan:
- Reset then single fetch (MEM_LATENCY=1): i_req_valid, addr 0x10, mem returns 0x00A00093 -> i_req_ready at T; mem_address = 0x10 at T+1; i_rsp_valid with data 0x00A00093 at T+2; busy high at T+1..T+2.
- Store: d_req addr 0x40, wdata 0xDEADBEEF, we=1 -> mem_write_enable high only at T+1 with address 0x40 and data 0xDEADBEEF; d_rsp_valid at T+2 with data 0.
- Tie with DATA_PRIORITY=1: both valid in the same cycle -> data granted first, fetch granted at the next IDLE. With DATA_PRIORITY=0 after reset and repeated ties -> grants alternate D, I, D, I.
- MEM_LATENCY=3 load at addr 0x8: mem_read_data changes each cycle -> captured value equals memory contents at 0x8 in cycle T+3; d_rsp_valid at T+4; i_req_ready stays 0 during T+1..T+4.
- rst pulsed during ACCESS of a store -> mem_write_enable drops asynchronously; no d_rsp_valid ever appears; first request after reset is accepted normally.
